// File: rtl/hazard_unit_pkg.sv
// hazard_pkg: forward-select codes, Tnew/Tuse constants and the per-stage hazard record.
package hazard_pkg;
    localparam int REG_W = 5;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E = 2'b01;
    localparam logic [1:0] FWD_M = 2'b10;
    localparam logic [1:0] FWD_W = 2'b11;
    localparam logic [1:0] TNEW_CALC = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam logic [1:0] TNEW_JAL = 2'd0;
    localparam logic [1:0] TUSE_NONE = 2'd3;
    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] a3;
        logic [1:0]       tnew;
    } hz_rec_t;
    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: D-stage classification/register fields in, stall and bypass selects out.
interface hazard_unit_if #(parameter int RA_W = 5);
    logic            d_isCalc_R, d_isCalc_I, d_isLoad, d_isStore, d_isBranch, d_isJal, d_isJr;
    logic [RA_W-1:0] d_rs, d_rt, d_rd;
    logic            stall, flush_E;
    logic [1:0]      fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
    logic            fwd_M_rt;
    modport master (
        output d_isCalc_R, d_isCalc_I, d_isLoad, d_isStore, d_isBranch, d_isJal, d_isJr,
        output d_rs, d_rt, d_rd,
        input  stall, flush_E, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt
    );
    modport slave (
        input  d_isCalc_R, d_isCalc_I, d_isLoad, d_isStore, d_isBranch, d_isJal, d_isJr,
        input  d_rs, d_rt, d_rd,
        output stall, flush_E, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt
    );
endinterface

// File: rtl/hazard_unit_hz_rec_reg.sv
// hz_rec_reg: one pipelined hazard record with async clear, bubble load and saturating Tnew countdown.
module hz_rec_reg
    import hazard_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    bubble_i,
    input  logic    dec_i,
    input  hz_rec_t rec_i,
    output hz_rec_t rec_o
);
    hz_rec_t rec_d, rec_q;
    always_comb begin
        rec_d = rec_i;
        rec_d.tnew = dec_i ? sat_dec(rec_i.tnew) : rec_i.tnew;
        if (bubble_i) rec_d = '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rec_q <= '0;
        else rec_q <= rec_d;
    end
    assign rec_o = rec_q;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/forward controller for the 5-stage MIPS pipeline.
// Define HAZARD_STALL_CNT_EN to add the 32-bit stall_cnt output.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int RA_W = 5,
    parameter int LINK_REG = 31
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef HAZARD_STALL_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    hazard_unit_if.slave hz
);
    hz_rec_t d_rec, e_q, m_q, w_q;
    logic [1:0] tuse_rs, tuse_rt;
    logic stall_rs, stall_rt;
    function automatic logic hit(input hz_rec_t r, input logic [REG_W-1:0] ra);
        return (r.a3 != '0) && (r.a3 == ra);
    endfunction
    function automatic logic ready(input hz_rec_t r, input logic [REG_W-1:0] ra);
        return hit(r, ra) && (r.tnew == 2'd0);
    endfunction
    function automatic logic busy(input logic [REG_W-1:0] ra, input logic [1:0] tuse);
        return (tuse != TUSE_NONE) && ((hit(e_q, ra) && e_q.tnew > tuse) || (hit(m_q, ra) && m_q.tnew > tuse));
    endfunction
    always_comb begin
        d_rec.rs = hz.d_rs;
        d_rec.rt = hz.d_rt;
        d_rec.a3 = hz.d_isLoad ? hz.d_rt : hz.d_isCalc_R ? hz.d_rd : hz.d_isCalc_I ? hz.d_rt :
                   hz.d_isJal ? RA_W'(LINK_REG) : '0;
        d_rec.tnew = hz.d_isLoad ? TNEW_LOAD : (hz.d_isCalc_R | hz.d_isCalc_I) ? TNEW_CALC : TNEW_JAL;
        tuse_rs = (hz.d_isBranch | hz.d_isJr) ? 2'd0 :
                  (hz.d_isCalc_R | hz.d_isCalc_I | hz.d_isLoad | hz.d_isStore) ? 2'd1 : TUSE_NONE;
        tuse_rt = hz.d_isBranch ? 2'd0 : hz.d_isCalc_R ? 2'd1 : hz.d_isStore ? 2'd2 : TUSE_NONE;
        stall_rs = busy(hz.d_rs, tuse_rs);
        stall_rt = busy(hz.d_rt, tuse_rt);
    end
    assign hz.stall = stall_rs | stall_rt;
    assign hz.flush_E = hz.stall;
    // Nearest producer wins: the younger the record, the higher its priority.
    assign hz.fwd_D_rs = ready(e_q, hz.d_rs) ? FWD_E : ready(m_q, hz.d_rs) ? FWD_M :
                         ready(w_q, hz.d_rs) ? FWD_W : FWD_RF;
    assign hz.fwd_D_rt = ready(e_q, hz.d_rt) ? FWD_E : ready(m_q, hz.d_rt) ? FWD_M :
                         ready(w_q, hz.d_rt) ? FWD_W : FWD_RF;
    assign hz.fwd_E_rs = ready(m_q, e_q.rs) ? FWD_M : ready(w_q, e_q.rs) ? FWD_W : FWD_RF;
    assign hz.fwd_E_rt = ready(m_q, e_q.rt) ? FWD_M : ready(w_q, e_q.rt) ? FWD_W : FWD_RF;
    assign hz.fwd_M_rt = ready(w_q, m_q.rt);
    hz_rec_reg u_rec_e (.clk(clk), .rst_n(rst_n), .bubble_i(hz.stall), .dec_i(1'b0), .rec_i(d_rec), .rec_o(e_q));
    hz_rec_reg u_rec_m (.clk(clk), .rst_n(rst_n), .bubble_i(1'b0), .dec_i(1'b1), .rec_i(e_q), .rec_o(m_q));
    hz_rec_reg u_rec_w (.clk(clk), .rst_n(rst_n), .bubble_i(1'b0), .dec_i(1'b1), .rec_i(m_q), .rec_o(w_q));
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    assign cnt_d = hz.stall ? cnt_q + 32'd1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign stall_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed instruction sequences checked against a stage-index pipeline model.
module tb_hazard_unit;
    typedef enum int {NOP, CALCR, CALCI, LOAD, STORE, BR, JAL, JR} cls_t;
    typedef struct {
        cls_t cls;
        int   rs;
        int   rt;
        int   rd;
    } ins_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    ins_t cur = '{NOP, 0, 0, 0};
    ins_t mq[3];
    int mcnt = 0;
    hazard_unit_if #(.RA_W(5)) hif ();
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
    hazard_unit dut (.clk(clk), .rst_n(rst_n), .stall_cnt(stall_cnt), .hz(hif));
`else
    hazard_unit dut (.clk(clk), .rst_n(rst_n), .hz(hif));
`endif
    always #5 clk = ~clk;

    function automatic int dst(ins_t i);
        return (i.cls == CALCR) ? i.rd : (i.cls == CALCI || i.cls == LOAD) ? i.rt : (i.cls == JAL) ? 31 : 0;
    endfunction
    // Result is available once the instruction sits in this stage index (0=E, 1=M, 2=W).
    function automatic int ready_at(ins_t i);
        return (i.cls == LOAD) ? 2 : (i.cls == CALCR || i.cls == CALCI) ? 1 : 0;
    endfunction
    function automatic int tnew_at(ins_t i, int idx);
        return (ready_at(i) > idx) ? ready_at(i) - idx : 0;
    endfunction
    function automatic int use_rs(ins_t i);
        return (i.cls == BR || i.cls == JR) ? 0 : (i.cls inside {CALCR, CALCI, LOAD, STORE}) ? 1 : 3;
    endfunction
    function automatic int use_rt(ins_t i);
        return (i.cls == BR) ? 0 : (i.cls == CALCR) ? 1 : (i.cls == STORE) ? 2 : 3;
    endfunction
    function automatic bit waits(int r, int tuse);
        for (int k = 0; k < 2; k++)
            if (tuse < 3 && dst(mq[k]) != 0 && dst(mq[k]) == r && tnew_at(mq[k], k) > tuse) return 1;
        return 0;
    endfunction
    function automatic bit m_stall();
        return waits(cur.rs, use_rs(cur)) || waits(cur.rt, use_rt(cur));
    endfunction
    function automatic int m_fwd(int r, int from);
        for (int k = from; k < 3; k++)
            if (r != 0 && dst(mq[k]) == r && tnew_at(mq[k], k) == 0) return k + 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) mq[k] <= '{NOP, 0, 0, 0};
            mcnt <= 0;
        end else begin
            mq[2] <= mq[1];
            mq[1] <= mq[0];
            mq[0] <= m_stall() ? '{NOP, 0, 0, 0} : cur;
            mcnt <= mcnt + int'(m_stall());
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("stall", 32'(hif.stall), 32'(m_stall()));
        chk("flush_E", 32'(hif.flush_E), 32'(m_stall()));
        chk("fwd_D_rs", 32'(hif.fwd_D_rs), 32'(m_fwd(cur.rs, 0)));
        chk("fwd_D_rt", 32'(hif.fwd_D_rt), 32'(m_fwd(cur.rt, 0)));
        chk("fwd_E_rs", 32'(hif.fwd_E_rs), 32'(m_fwd(mq[0].rs, 1)));
        chk("fwd_E_rt", 32'(hif.fwd_E_rt), 32'(m_fwd(mq[0].rt, 1)));
        chk("fwd_M_rt", 32'(hif.fwd_M_rt), 32'(m_fwd(mq[1].rt, 2) == 3));
`ifdef HAZARD_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(mcnt));
`endif
    end

    task automatic drive(cls_t c, int rs, int rt, int rd);
        cur = '{c, rs, rt, rd};
        hif.d_isCalc_R = (c == CALCR);
        hif.d_isCalc_I = (c == CALCI);
        hif.d_isLoad = (c == LOAD);
        hif.d_isStore = (c == STORE);
        hif.d_isBranch = (c == BR);
        hif.d_isJal = (c == JAL);
        hif.d_isJr = (c == JR);
        hif.d_rs = 5'(rs);
        hif.d_rt = 5'(rt);
        hif.d_rd = 5'(rd);
    endtask
    task automatic step(cls_t c, int rs, int rt, int rd);
        @(posedge clk);
        #1 drive(c, rs, rt, rd);
        @(negedge clk);
        #1;
    endtask
    task automatic drain();
        repeat (3) step(NOP, 0, 0, 0);
    endtask
    task automatic zero_outs(string nm);
        chk({nm, "_stall"}, 32'(hif.stall), 0);
        chk({nm, "_flush"}, 32'(hif.flush_E), 0);
        chk({nm, "_fwd"}, {23'd0, hif.fwd_D_rs, hif.fwd_D_rt, hif.fwd_E_rs, hif.fwd_E_rt, hif.fwd_M_rt}, 0);
    endtask

    initial begin
        drive(NOP, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1 zero_outs("reset");
        rst_n = 1'b1;
        // load-use: lw $8 ; addu $9,$8,$1
        step(LOAD, 0, 8, 0);
        step(CALCR, 8, 1, 9);
        chk("lu_stall", 32'(hif.stall), 1);
        chk("lu_flush", 32'(hif.flush_E), 1);
        step(CALCR, 8, 1, 9);
        chk("lu_release", 32'(hif.stall), 0);
        step(NOP, 0, 0, 0);
        chk("lu_fwd_E_rs", 32'(hif.fwd_E_rs), 32'b11);
        drain();
        // calc-branch: addu $3 ; beq $3,$0
        step(CALCR, 1, 2, 3);
        step(BR, 3, 0, 0);
        chk("cb_stall", 32'(hif.stall), 1);
        step(BR, 3, 0, 0);
        chk("cb_release", 32'(hif.stall), 0);
        chk("cb_fwd_D_rs", 32'(hif.fwd_D_rs), 32'b10);
        drain();
        // jal ; jr $31
        step(JAL, 0, 0, 0);
        step(JR, 31, 0, 0);
        chk("jr_stall", 32'(hif.stall), 0);
        chk("jr_fwd_D_rs", 32'(hif.fwd_D_rs), 32'b01);
        drain();
        // lw $4 ; sw $4,0($5)
        step(LOAD, 0, 4, 0);
        step(STORE, 5, 4, 0);
        chk("sw_stall", 32'(hif.stall), 0);
        step(NOP, 0, 0, 0);
        step(NOP, 0, 0, 0);
        chk("sw_fwd_M_rt", 32'(hif.fwd_M_rt), 1);
        drain();
        // back-to-back calc: addu $6 ; addu $7,$6,$6
        step(CALCR, 1, 2, 6);
        step(CALCR, 6, 6, 7);
        chk("cc_stall", 32'(hif.stall), 0);
        step(NOP, 0, 0, 0);
        chk("cc_fwd_E_rs", 32'(hif.fwd_E_rs), 32'b10);
        chk("cc_fwd_E_rt", 32'(hif.fwd_E_rt), 32'b10);
        drain();
        // register 0: ori $0,$0,5 ; addu $2,$0,$0
        step(CALCI, 0, 0, 0);
        step(CALCR, 0, 0, 2);
        zero_outs("r0_d");
        step(NOP, 0, 0, 0);
        zero_outs("r0_e");
        drain();
        // reset during a stall that also carries live forwards
        step(CALCR, 1, 2, 10);
        step(LOAD, 10, 8, 0);
        step(CALCR, 8, 10, 9);
        chk("rs_stall", 32'(hif.stall), 1);
        chk("rs_fwd_D_rt", 32'(hif.fwd_D_rt), 32'b10);
        chk("rs_fwd_E_rs", 32'(hif.fwd_E_rs), 32'b10);
        rst_n = 1'b0;
        #1 zero_outs("rs_async");
        #2 rst_n = 1'b1;
        step(NOP, 0, 0, 0);
        zero_outs("rs_after");
`ifdef HAZARD_STALL_CNT_EN
        chk("rs_cnt", stall_cnt, 0);
`endif
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Stall/forward controller for the 5-stage MIPS pipeline (F/D/E/M/W). It sits directly downstream of the D-stage decoder.
- Consumes the decoder's classification outputs (isCalc_R, isCalc_I, isLoad, isStore, isBranch, isJal, isJr) plus register fields of the D-stage instruction.
- Internally pipelines a hazard record per in-flight instruction (E, M, W), counts down Tnew, and drives the stall, the E bubble insert and all bypass-mux selects.

Parameters:
- RA_W, 5, register-address width.
- LINK_REG, 31, destination register written by jal.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- d_isCalc_R / d_isCalc_I / d_isLoad / d_isStore / d_isBranch / d_isJal / d_isJr  input  1 each  D-stage instruction class from the decoder.
- d_rs  input  RA_W  Instr[25:21] in D.
- d_rt  input  RA_W  Instr[20:16] in D.
- d_rd  input  RA_W  Instr[15:11] in D.
- stall  output  1  freeze PC and IF/ID register.
- flush_E  output  1  load bubble into ID/EX (equals stall).
- fwd_D_rs, fwd_D_rt  output  2  D comparator/jr operand select: 00 RF, 01 E, 10 M, 11 W.
- fwd_E_rs, fwd_E_rt  output  2  ALU operand select: 00 pipeline reg, 10 M, 11 W.
- fwd_M_rt  output  1  DM write-data select: 0 pipeline reg, 1 W.

Behaviour:
- Record fields, one each for E, M, W: rs, rt, a3 (destination, 0 = no write), tnew (2 bits).
- D-record construction:
  - calc_R: a3 = rd, tnew = 1.
  - calc_I: a3 = rt, tnew = 1.
  - load: a3 = rt, tnew = 2.
  - jal: a3 = LINK_REG, tnew = 0.
  - otherwise: a3 = 0, tnew = 0.
- Tuse(rs) = 0 for branch/jr; 1 for calc_R/calc_I/load/store; else 3 (unused).
- Tuse(rt) = 0 for branch; 1 for calc_R; 2 for store; else 3.
- Stall (combinational):
  - Asserted if, for rs or rt in D with Tuse < 3, there exists E or M record with a3 != 0, a3 == reg, and tnew > Tuse.
  - W never causes a stall.
- Clock edge, stall = 0: E <= D-record; M <= E with tnew = sat_dec(tnew); W <= M with tnew = sat_dec(tnew).
- Clock edge, stall = 1: E <= bubble (all fields 0); M and W advance as above.
- sat_dec(x) = 0 if x = 0, else x-1.
- Forwarding applies only to records with a3 != 0 and tnew == 0. For each consumer, the nearest matching producer wins:
  - D consumer: priority E > M > W.
  - E consumer: priority M > W.
  - M consumer: W.
  - Register 0 never matches.
- Outputs are combinational from records and D inputs; forward and stall take effect in the same cycle. No added latency.
- Reset (asynchronous, any time including mid-stall): all records become bubbles.
  - stall = 0, flush_E = 0, all fwd_* = 0 immediately and while rst_n = 0.
- Simultaneous stall and forward: fwd_D_* still reflects the current records. stall dominates; the D instruction re-evaluates next cycle.
- Multiple D classes asserted simultaneously is illegal input; the priority order for record construction is load > calc_R > calc_I > jal.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined:
  - Extra output stall_cnt (32 bits).
  - Reset to 0 on rst_n = 0.
  - Increments by 1 on each clock edge with stall = 1, wrapping 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package hazard_pkg holds:
  - forward-select encodings (FWD_RF=00, FWD_E=01, FWD_M=10, FWD_W=11);
  - TNEW_CALC=1, TNEW_LOAD=2, TNEW_JAL=0, TUSE_NONE=3;
  - the hazard-record struct typedef.
- One sub-module, hz_rec_reg: a record register with async active-low clear, bubble-load input and saturating tnew decrement. It is instantiated three times (E, M, W).
- Stall and forward logic stays in the top module.

Test Plan:
- Load-use: lw $8 in D, then addu $9,$8,$1.
  - Expected: stall = 1 and flush_E = 1 for exactly 1 cycle.
  - Next cycle: stall = 0 and fwd_E_rs = 11 (W) when addu reaches E.
- Calc-branch: addu $3 followed by beq $3,$0.
  - Expected: stall = 1 for 1 cycle.
  - Then fwd_D_rs = 10 (M).
- jal then jr $31 next:
  - Expected: stall = 0 and fwd_D_rs = 01 (E) in the same cycle.
- Store data: lw $4 then sw $4,0($5).
  - Expected: no stall (Tuse 2 == Tnew 2).
  - fwd_M_rt = 1 when sw is in M.
- Register 0: ori $0,$0,5 then addu $2,$0,$0.
  - Expected: stall = 0 and all fwd_* = 0.
- Reset mid-stall: assert rst_n = 0 while stall = 1.
  - Expected: stall, flush_E and fwd_* drop to 0 asynchronously.
  - After release: no stale forwarding; stall_cnt = 0 when HAZARD_STALL_CNT_EN is defined.
